// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with execute-stage operand selection.
// Captures decoded fields and resolves EX/MEM and MEM/WB forwarding
// on the captured register indices. Produces the ALU operands and the
// store data, and detects load-use hazards against the decode stage.
module id_ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidD,
  input  logic [XLEN-1:0]       RD1D,
  input  logic [XLEN-1:0]       RD2D,
  input  logic [XLEN-1:0]       PCD,
  input  logic [XLEN-1:0]       ImmExtD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic [3:0]            ALUControlD,
  input  logic [1:0]            ALUSrcAD,
  input  logic                  ALUSrcBD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic                  BranchD,
  input  logic                  JumpD,
  input  logic                  FlushE,
  input  logic                  StallE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [XLEN-1:0]       ALUResultM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteW,
  input  logic [XLEN-1:0]       ResultW,
  output logic [XLEN-1:0]       SrcAE,
  output logic [XLEN-1:0]       SrcBE,
  output logic [XLEN-1:0]       WriteDataE,
  output logic [3:0]            ALUControlE,
  output logic [XLEN-1:0]       PCE,
  output logic [XLEN-1:0]       ImmExtE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [1:0]            ResultSrcE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic                  ValidE,
  output logic                  LoadUseStallD
);

  // All-zero value of this struct is the bubble (and the reset state).
  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            alu_ctrl;
    logic [1:0]            srca_sel;
    logic                  srcb_sel;
    logic [1:0]            result_src;
    logic                  regwrite;
    logic                  memwrite;
    logic                  branch;
    logic                  jump;
  } ex_fields_t;

  ex_fields_t ex_reg;
  ex_fields_t d_fields;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // Nearest producer wins: MEM before WB, and x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(input logic [REG_ADDR_W-1:0] rs,
                                          input logic [XLEN-1:0]       rf_val);
    if (RegWriteM && (RdM != '0) && (RdM == rs))
      return ALUResultM;
    else if (RegWriteW && (RdW != '0) && (RdW == rs))
      return ResultW;
    else
      return rf_val;
  endfunction

  // Pack the decode-stage fields into the EX record layout.
  always_comb begin
    d_fields            = '0;
    d_fields.valid      = ValidD;
    d_fields.rd1        = RD1D;
    d_fields.rd2        = RD2D;
    d_fields.pc         = PCD;
    d_fields.imm        = ImmExtD;
    d_fields.rs1        = Rs1D;
    d_fields.rs2        = Rs2D;
    d_fields.rd         = RdD;
    d_fields.alu_ctrl   = ALUControlD;
    d_fields.srca_sel   = ALUSrcAD;
    d_fields.srcb_sel   = ALUSrcBD;
    d_fields.result_src = ResultSrcD;
    d_fields.regwrite   = RegWriteD;
    d_fields.memwrite   = MemWriteD;
    d_fields.branch     = BranchD;
    d_fields.jump       = JumpD;
  end

  // Load-use detection; conservatively compares rs2 even when unused.
  // Suppressed while EX is flushed or held since no new fetch advances.
  always_comb begin
    LoadUseStallD = ex_reg.valid && ex_reg.regwrite &&
                    (ex_reg.result_src == 2'b01) && (ex_reg.rd != '0) &&
                    ((ex_reg.rd == Rs1D) || (ex_reg.rd == Rs2D)) &&
                    !FlushE && !StallE;
  end

  // EX register: flush beats stall, stall beats load-use bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ex_reg <= '0;
    else if (FlushE)
      ex_reg <= '0;
    else if (!StallE) begin
      if (LoadUseStallD || !ValidD)
        ex_reg <= '0;
      else
        ex_reg <= d_fields;
    end
  end

  // Forwarded operands and ALU source muxes.
  always_comb begin
    rs1_fwd = fwd(ex_reg.rs1, ex_reg.rd1);
    rs2_fwd = fwd(ex_reg.rs2, ex_reg.rd2);
    unique case (ex_reg.srca_sel)
      2'b00:   SrcAE = rs1_fwd;
      2'b01:   SrcAE = ex_reg.pc;
      default: SrcAE = '0;
    endcase
    SrcBE      = ex_reg.srcb_sel ? ex_reg.imm : rs2_fwd;
    WriteDataE = rs2_fwd;
  end

  assign ALUControlE = ex_reg.alu_ctrl;
  assign PCE         = ex_reg.pc;
  assign ImmExtE     = ex_reg.imm;
  assign RdE         = ex_reg.rd;
  assign ResultSrcE  = ex_reg.result_src;
  assign RegWriteE   = ex_reg.regwrite;
  assign MemWriteE   = ex_reg.memwrite;
  assign BranchE     = ex_reg.branch;
  assign JumpE       = ex_reg.jump;
  assign ValidE      = ex_reg.valid;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus execute-stage operand selection for the 5-stage RV32I core.
- Latches decoded fields each cycle and resolves EX/MEM and MEM/WB forwarding.
- Selects the ALU operands SrcAE/SrcBE and the store data WriteDataE. Drives the ALU directly.
- Detects load-use hazards, stalls decode and inserts one bubble.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- ValidD  input  1  decode holds a real instruction
- RD1D, RD2D  input  XLEN  register-file read data
- PCD  input  XLEN  instruction PC
- ImmExtD  input  XLEN  sign-extended immediate
- Rs1D, Rs2D, RdD  input  REG_ADDR_W  register indices
- ALUControlD  input  4  ALU op code, ALU encoding (0000 ADD ... 1010 SRA)
- ALUSrcAD  input  2  00 = rs1, 01 = PC, 10 = zero (LUI), 11 = zero
- ALUSrcBD  input  1  0 = rs2, 1 = immediate
- ResultSrcD  input  2  00 = ALU, 01 = load, 10 = PC+4
- RegWriteD, MemWriteD, BranchD, JumpD  input  1 each  control
- FlushE  input  1  branch redirect: bubble into EX
- StallE  input  1  downstream stall: hold EX
- RdM  input  REG_ADDR_W  EX/MEM destination
- RegWriteM  input  1  EX/MEM writes a register
- ALUResultM  input  XLEN  EX/MEM ALU result
- RdW  input  REG_ADDR_W  MEM/WB destination
- RegWriteW  input  1  MEM/WB writes a register
- ResultW  input  XLEN  writeback value
- SrcAE, SrcBE  output  XLEN  ALU operands
- WriteDataE  output  XLEN  forwarded rs2, used as store data
- ALUControlE  output  4  registered ALU op
- PCE, ImmExtE  output  XLEN  registered
- RdE  output  REG_ADDR_W  registered
- ResultSrcE  output  2  registered
- RegWriteE, MemWriteE, BranchE, JumpE, ValidE  output  1 each  registered
- LoadUseStallD  output  1  stall PC and IF/ID this cycle

Behaviour:
- Reset (async, rst=1): every register is cleared to 0. With Rs1E=0 this gives SrcAE=SrcBE=WriteDataE=0, ALUControlE=ADD, LoadUseStallD=0.
- Register update priority at each rising clk edge:
  - FlushE: load bubble.
  - else StallE: hold all registers.
  - else LoadUseStallD: load bubble.
  - else: load the D-stage fields.
- Bubble: all registers zero, i.e. ValidE=RegWriteE=MemWriteE=BranchE=JumpE=0, RdE=0, ALUControlE=0000.
- ValidD=0 loads as a bubble.
- Forwarding is combinational on the registered Rs1E/Rs2E (Rs1E/Rs2E are internal registers). For each operand:
  - if RegWriteM and RdM!=0 and RdM==RsE, use ALUResultM;
  - else if RegWriteW and RdW!=0 and RdW==RsE, use ResultW;
  - else use the registered RD1E/RD2E.
- MEM beats WB when both match. x0 is never forwarded.
- SrcAE = forwarded rs1, PCE or 0 per the registered ALUSrcA; code 11 also gives 0.
- SrcBE = forwarded rs2 or ImmExtE per the registered ALUSrcB. WriteDataE is always the forwarded rs2.
- Load-use: LoadUseStallD = ValidE & RegWriteE & (ResultSrcE==01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
  - It is combinational and does not check whether the instruction actually uses rs2, so a false stall is acceptable.
  - It is suppressed (forced 0) while FlushE=1 or StallE=1.
- Latency: D fields appear on the E outputs one cycle after capture. Forwarding adds no cycle.
- No arithmetic in this block. Widths pass straight through and no truncation occurs.
- rst asserted mid-stream clears immediately and asynchronously. The first edge after release loads D normally.

Test Plan:
- Reset: hold rst with RD1D=0xDEADBEEF. Release, present ADD x3,x1,x2 (RD1D=5, RD2D=7, Rs1D=1, Rs2D=2, ALUSrcB=0), one clk -> SrcAE=5, SrcBE=7, RegWriteE=1, RdE=3; during reset all outputs are 0.
- Forward priority: E holds Rs1E=4. RdM=4, RegWriteM=1, ALUResultM=0x11; RdW=4, RegWriteW=1, ResultW=0x22 -> SrcAE=0x11. Drop RegWriteM -> SrcAE=0x22. Set RdM=RdW=0 -> SrcAE=RD1E.
- Load-use: E holds LW x5 (ResultSrcE=01, RegWriteE=1); D has Rs1D=5 -> LoadUseStallD=1. Next edge E is a bubble (ValidE=0, RegWriteE=0). After that edge the load is in MEM, stall drops, the consumer enters E and forwards via W.
- Flush vs stall: FlushE=1 and StallE=1 together -> bubble loaded, LoadUseStallD=0. StallE alone for 3 cycles -> all E outputs constant.
- Operand select: AUIPC (ALUSrcA=01, PCD=0x100, ImmExtD=0x2000, ALUSrcB=1) -> SrcAE=0x100, SrcBE=0x2000. LUI (ALUSrcA=10) -> SrcAE=0. A store with RdM matching Rs2E -> WriteDataE=ALUResultM while SrcBE=imm.
- Async reset mid-stream: assert rst between clock edges with ValidE=1 -> ValidE=0 and RegWriteE=0 before the next edge.
